// File: rtl/spi_xfer.sv
// SPI mode-0 byte shifter shared between Z80 port access and a DMA requester.
// One byte per start; MSB first; SCK half-period is CLKDIV clk cycles.
// The Z80 side has priority when both sides request in the same idle cycle.
module spi_xfer #(
    parameter int unsigned CLKDIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dma_req,
    input  logic [7:0] dma_wrdata,
    output logic [7:0] dma_rddata,
    output logic       dma_stb,
    input  logic       z_wr_data,
    input  logic       z_rd_data,
    input  logic       z_wr_ctrl,
    input  logic [7:0] zdata,
    output logic [7:0] z_rddata,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLKDIV - 1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  shift_r;
    logic [7:0]  rx_r;
    logic [3:0]  div_r;
    logic [2:0]  bit_r;
    logic        sck_r;
    logic        miso_r;
    logic        owner_dma_r;
    logic        cs_n_r;
    logic        stb_r;

    logic        start_s;
    logic        owner_dma_s;
    logic [7:0]  tx_s;
    logic        toggle_s;
    logic        rise_s;
    logic        fall_s;
    logic        last_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: DONE always returns to IDLE, forcing one idle cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_SHIFT;
                else         state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_SHIFT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Control decode: start arbitration in IDLE, SCK edge events in SHIFT
    always_comb begin
        start_s     = 1'b0;
        owner_dma_s = 1'b0;
        tx_s        = 8'hFF;
        toggle_s    = 1'b0;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (z_wr_data) begin
                    start_s = 1'b1;
                    tx_s    = zdata;
                end else if (z_rd_data) begin
                    start_s = 1'b1;
                    tx_s    = 8'hFF;
                end else if (dma_req) begin
                    start_s     = 1'b1;
                    tx_s        = dma_wrdata;
                    owner_dma_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                toggle_s = (div_r == DIV_LAST);
                rise_s   = toggle_s & ~sck_r;
                fall_s   = toggle_s & sck_r;
                last_s   = fall_s & (bit_r == 3'd7);
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Divider and SCK generation; SCK is parked low outside SHIFT
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= 4'd0;
            sck_r <= 1'b0;
        end else if (state_r == ST_SHIFT) begin
            if (toggle_s) begin
                div_r <= 4'd0;
                sck_r <= ~sck_r;
            end else begin
                div_r <= div_r + 4'd1;
            end
        end else begin
            div_r <= 4'd0;
            sck_r <= 1'b0;
        end
    end

    // Shift datapath: MISO held at the rising toggle, shifted in at the falling one
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r     <= 8'hFF;
            bit_r       <= 3'd0;
            miso_r      <= 1'b0;
            owner_dma_r <= 1'b0;
        end else if (start_s) begin
            shift_r     <= tx_s;
            bit_r       <= 3'd0;
            owner_dma_r <= owner_dma_s;
        end else if (rise_s) begin
            miso_r <= spi_miso;
        end else if (fall_s) begin
            shift_r <= {shift_r[6:0], miso_r};
            bit_r   <= bit_r + 3'd1;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Receive register and DMA strobe, both valid during the DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_r  <= 8'hFF;
            stb_r <= 1'b0;
        end else begin
            stb_r <= last_s & owner_dma_r;
            if (last_s) rx_r <= {shift_r[6:0], miso_r};
            else        rx_r <= rx_r;
        end
    end

    // Chip select written from the control port at any time
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_r <= 1'b1;
        end else if (z_wr_ctrl) begin
            cs_n_r <= zdata[0];
        end else begin
            cs_n_r <= cs_n_r;
        end
    end

    assign busy       = (state_r != ST_IDLE);
    assign spi_sck    = sck_r;
    assign spi_mosi   = shift_r[7];
    assign spi_cs_n   = cs_n_r;
    assign dma_stb    = stb_r;
    assign dma_rddata = rx_r;
    assign z_rddata   = rx_r;

endmodule

// File: tb/tb_spi_xfer.sv
// Randomised bench for spi_xfer with a cycle-count reference model, an SPI
// slave that returns a table of bytes, and directed literal scenarios.
module tb_spi_xfer;

    localparam int CLKDIV = 2;
    localparam int XFER_BUSY = 16 * CLKDIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       dma_req;
    logic [7:0] dma_wrdata;
    logic [7:0] dma_rddata;
    logic       dma_stb;
    logic       z_wr_data;
    logic       z_rd_data;
    logic       z_wr_ctrl;
    logic [7:0] zdata;
    logic [7:0] z_rddata;
    logic       busy;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;

    int total = 0;
    int bad   = 0;

    // slave side
    logic [7:0] resp_tbl [0:255];
    logic [7:0] slv_sreg = 8'hFF;
    logic [7:0] mosi_cap = 8'h00;
    int         slv_pulses = 0;

    // reference model state
    int         m_left = 0;
    logic       m_owner_dma = 1'b0;
    logic [7:0] m_tx = 8'hFF;
    logic [7:0] m_resp = 8'hFF;
    logic       m_stb = 1'b0;
    logic [7:0] m_rx = 8'hFF;
    logic       m_cs = 1'b1;
    int         n_start = 0;

    spi_xfer #(.CLKDIV(CLKDIV)) dut (
        .clk(clk), .reset(reset),
        .dma_req(dma_req), .dma_wrdata(dma_wrdata), .dma_rddata(dma_rddata), .dma_stb(dma_stb),
        .z_wr_data(z_wr_data), .z_rd_data(z_rd_data), .z_wr_ctrl(z_wr_ctrl), .zdata(zdata),
        .z_rddata(z_rddata), .busy(busy),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    always #5 clk = ~clk;

    assign spi_miso = slv_sreg[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic z_write(input logic [7:0] b);
        zdata = b;
        z_wr_data = 1'b1;
        @(negedge clk);
        z_wr_data = 1'b0;
    endtask

    // Slave: present next bit after each falling SCK, capture MOSI on rising SCK
    initial forever begin
        @(negedge spi_sck);
        slv_sreg = {slv_sreg[6:0], 1'b1};
    end
    initial forever begin
        @(posedge spi_sck);
        mosi_cap = {mosi_cap[6:0], spi_mosi};
        slv_pulses++;
    end

    // Reference model: a byte keeps the block busy for 16*CLKDIV+1 cycles after
    // the accepting edge; the last of those cycles delivers the byte.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_left = 0;
            m_stb  = 1'b0;
            m_rx   = 8'hFF;
            m_cs   = 1'b1;
        end else begin
            if (z_wr_ctrl) m_cs = zdata[0];
            if (m_left > 0) begin
                m_left--;
            end else if (z_wr_data || z_rd_data || dma_req) begin
                m_left      = XFER_BUSY;
                m_owner_dma = !z_wr_data && !z_rd_data;
                m_tx        = z_wr_data ? zdata : (z_rd_data ? 8'hFF : dma_wrdata);
                m_resp      = resp_tbl[n_start % 256];
                slv_sreg    = m_resp;
                slv_pulses  = 0;
                mosi_cap    = 8'h00;
                n_start++;
            end
            m_stb = (m_left == 1) && m_owner_dma;
            if (m_left == 1) m_rx = m_resp;
        end
    end

    // Per-cycle comparison against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy", busy, (m_left > 0));
            check("dma_stb", dma_stb, m_stb);
            check("dma_rddata", dma_rddata, m_rx);
            check("z_rddata", z_rddata, m_rx);
            check("cs_n", spi_cs_n, m_cs);
            if (m_left == 0) check("sck_idle", spi_sck, 1'b0);
            if (m_left == 1 && !reset) begin
                check("mosi_byte", mosi_cap, m_tx);
                check("sck_pulses", slv_pulses, 8);
                check("sck_done", spi_sck, 1'b0);
            end
        end
    end

    initial begin
        int ok;
        int busy_cnt;
        int stb_cnt;
        int n0;
        int stb_cyc [0:1];
        logic [7:0] stb_dat [0:1];

        for (int i = 0; i < 256; i++) resp_tbl[i] = 8'($urandom_range(0, 255));
        reset = 1'b1; dma_req = 1'b0; dma_wrdata = 8'h00; z_wr_data = 1'b0;
        z_rd_data = 1'b0; z_wr_ctrl = 1'b0; zdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rx", dma_rddata, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_cs", spi_cs_n, 1'b1);
        check("rst_mosi", spi_mosi, 1'b1);
        check("rst_stb", dma_stb, 1'b0);

        // reset during the fourth SCK pulse aborts the byte
        resp_tbl[n_start % 256] = 8'h5A;
        z_write(8'hA5);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (slv_pulses >= 4) begin ok = 1; break; end
        end
        check("abort_reach_p4", ok, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_sck", spi_sck, 1'b0);
        check("abort_cs", spi_cs_n, 1'b1);
        check("abort_rx", z_rddata, 8'hFF);
        check("abort_stb", dma_stb, 1'b0);
        @(negedge clk);

        // Z80 write A5, slave returns 3C
        resp_tbl[n_start % 256] = 8'h3C;
        z_write(8'hA5);
        busy_cnt = 0; stb_cnt = 0;
        if (busy) busy_cnt++;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (dma_stb) stb_cnt++;
        end
        check("z80_busy_cycles", busy_cnt, 33);
        check("z80_rx", z_rddata, 8'h3C);
        check("z80_mosi", mosi_cap, 8'hA5);
        check("z80_no_stb", stb_cnt, 0);

        // continuous DMA: two bytes, strobes 34 cycles apart
        resp_tbl[n_start % 256] = 8'h11;
        resp_tbl[(n_start + 1) % 256] = 8'h22;
        dma_wrdata = 8'hFF; dma_req = 1'b1; stb_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (dma_stb) begin
                if (stb_cnt < 2) begin stb_cyc[stb_cnt] = c; stb_dat[stb_cnt] = dma_rddata; end
                stb_cnt++;
                if (stb_cnt == 2) dma_req = 1'b0;
            end
        end
        check("dma_stb_count", stb_cnt, 2);
        check("dma_stb_gap", stb_cyc[1] - stb_cyc[0], 34);
        check("dma_rx0", stb_dat[0], 8'h11);
        check("dma_rx1", stb_dat[1], 8'h22);

        // Z80 and DMA in the same idle cycle: Z80 first, DMA follows with strobe
        n0 = n_start;
        resp_tbl[n0 % 256] = 8'h4E;
        resp_tbl[(n0 + 1) % 256] = 8'hB1;
        dma_wrdata = 8'h96; dma_req = 1'b1;
        z_write(8'hC3);
        stb_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            if (busy && c == 40) check("prio_first_rx", z_rddata, 8'h4E);
            @(negedge clk);
            if (dma_stb) begin
                stb_cnt++;
                stb_dat[0] = dma_rddata;
                dma_req = 1'b0;
            end
        end
        check("prio_stb_count", stb_cnt, 1);
        check("prio_dma_rx", stb_dat[0], 8'hB1);
        check("prio_starts", n_start - n0, 2);

        // Z80 write during SHIFT is ignored
        n0 = n_start;
        z_write(8'h3A);
        repeat (10) @(negedge clk);
        z_write(8'h77);
        repeat (60) @(negedge clk);
        check("ignore_mosi", mosi_cap, 8'h3A);
        check("ignore_starts", n_start - n0, 1);

        // chip select from the control port, idle and busy
        zdata = 8'h00; z_wr_ctrl = 1'b1;
        @(negedge clk);
        z_wr_ctrl = 1'b0;
        check("cs_low", spi_cs_n, 1'b0);
        z_write(8'h81);
        repeat (5) @(negedge clk);
        zdata = 8'h01; z_wr_ctrl = 1'b1;
        @(negedge clk);
        z_wr_ctrl = 1'b0;
        check("cs_high", spi_cs_n, 1'b1);
        check("cs_busy", busy, 1'b1);
        repeat (60) @(negedge clk);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            z_wr_data  = ($urandom_range(0, 15) == 0);
            z_rd_data  = ($urandom_range(0, 15) == 0);
            dma_req    = ($urandom_range(0, 3) != 0);
            z_wr_ctrl  = ($urandom_range(0, 19) == 0);
            zdata      = 8'($urandom_range(0, 255));
            dma_wrdata = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        z_wr_data = 1'b0; z_rd_data = 1'b0; dma_req = 1'b0; z_wr_ctrl = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
